// File: rtl/game_ctrl.sv
// game_ctrl: top-level game sequencer feeding the bird sprite stage.
// Generates the frame strobe and the animation counter, runs the
// IDLE/PLAY/OVER game FSM, and keeps the current and high scores.
//
// Ports:
//   clk, rst_n    system clock (rising edge), async active-low reset
//   start         raw start button, asynchronous to clk
//   hit           bird/pipe overlap level from the collision stage
//   pipe_pass     one-clk pulse when a pipe passes the bird
//   birdy[10:0]   current bird top-left y
//   frame_tick    one-clk frame strobe every FRAME_DIV clks
//   state[2:0]    one-hot game state: 001 IDLE, 010 PLAY, 100 OVER
//   count[5:0]    animation counter, 0..ANIM_WRAP-1
//   score[9:0]    current score (saturating)
//   high_score    best score since reset
//   game_over     one-clk pulse on the PLAY->OVER transition
module game_ctrl #(
    parameter int unsigned FRAME_DIV   = 1666667,
    parameter int unsigned ANIM_WRAP   = 60,
    parameter int unsigned Y_MAX       = 934,
    parameter int unsigned HOLD_FRAMES = 90,
    parameter int unsigned SCORE_MAX   = 999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        hit,
    input  logic        pipe_pass,
    input  logic [10:0] birdy,
    output logic        frame_tick,
    output logic [2:0]  state,
    output logic [5:0]  count,
    output logic [9:0]  score,
    output logic [9:0]  high_score,
    output logic        game_over
);

    localparam int unsigned DIV_W  = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_PLAY = 3'b010,
        ST_OVER = 3'b100
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DIV_W-1:0]    div_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   hold_d;
    logic [9:0]          score_d;
    logic [9:0]          high_d;
    logic                game_over_d;
    logic [2:0]          sync_q;
    logic                start_rise_c;

    assign state = state_q;

    // Frame divider; the tick is registered one clk early so it is high
    // exactly while the divider sits at FRAME_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= '0;
            frame_tick <= 1'b0;
        end else begin
            if (div_q == DIV_W'(FRAME_DIV - 1)) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
            frame_tick <= (div_q == DIV_W'(FRAME_DIV - 2));
        end
    end

    // Animation counter, free-running in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (frame_tick) begin
            if (count == 6'(ANIM_WRAP - 1)) begin
                count <= '0;
            end else begin
                count <= count + 6'd1;
            end
        end
    end

    // Start button: two-flop synchronizer plus one delayed copy for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], start};
        end
    end

    assign start_rise_c = sync_q[1] & ~sync_q[2];

    // FSM state and its registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            score      <= '0;
            high_score <= '0;
            game_over  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            score      <= score_d;
            high_score <= high_d;
            game_over  <= game_over_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        score_d     = score;
        high_d      = high_score;
        game_over_d = 1'b0;

        // game_over is still high on the first clk in OVER; score is final then.
        if ((state_q == ST_OVER) && game_over && (score > high_score)) begin
            high_d = score;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_rise_c) begin
                    state_d = ST_PLAY;
                    score_d = '0;
                end
            end
            ST_PLAY: begin
                if (pipe_pass && (score < 10'(SCORE_MAX))) begin
                    score_d = score + 10'd1;
                end
                // Ceiling wrap (birdy underflow) also lands above Y_MAX.
                if (frame_tick && (hit || (birdy > 11'(Y_MAX)))) begin
                    state_d     = ST_OVER;
                    game_over_d = 1'b1;
                    hold_d      = HOLD_W'(HOLD_FRAMES);
                end
            end
            ST_OVER: begin
                if (start_rise_c && (hold_q == '0)) begin
                    state_d = ST_IDLE;
                end else if (frame_tick && (hold_q != '0)) begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Testbench for game_ctrl: directed scenarios plus randomized stimulus,
// checked every clk against a behavioural model of the game rules.
module tb_game_ctrl;

    localparam int FD = 4;
    localparam int AW = 60;
    localparam int YM = 934;
    localparam int HF = 3;
    localparam int SM = 999;

    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_PLAY = 3'b010;
    localparam logic [2:0] S_OVER = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        hit;
    logic        pipe_pass;
    logic [10:0] birdy;
    logic        frame_tick;
    logic [2:0]  state;
    logic [5:0]  count;
    logic [9:0]  score;
    logic [9:0]  high_score;
    logic        game_over;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: n = clk edges since reset release; tick and count follow from n.
    int unsigned n;
    logic [2:0]  m_state;
    int          m_score;
    int          m_high;
    int          m_hold;
    bit          m_go;
    bit          hist [3];

    game_ctrl #(
        .FRAME_DIV  (FD),
        .ANIM_WRAP  (AW),
        .Y_MAX      (YM),
        .HOLD_FRAMES(HF),
        .SCORE_MAX  (SM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .hit       (hit),
        .pipe_pass (pipe_pass),
        .birdy     (birdy),
        .frame_tick(frame_tick),
        .state     (state),
        .count     (count),
        .score     (score),
        .high_score(high_score),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_tick();
        return (n % FD) == (FD - 1);
    endfunction

    function automatic int m_count();
        return int'((n / FD) % AW);
    endfunction

    task automatic model_reset();
        n       = 0;
        m_state = S_IDLE;
        m_score = 0;
        m_high  = 0;
        m_hold  = 0;
        m_go    = 1'b0;
        for (int i = 0; i < 3; i++) hist[i] = 1'b0;
    endtask

    // Advance the model across one clk edge with the inputs seen at that edge.
    task automatic model_step(input bit s, input bit h, input bit p, input int b);
        bit tick;
        bit rise;
        bit go_next;
        tick    = m_tick();
        rise    = hist[1] && !hist[2];
        go_next = 1'b0;
        if (m_state == S_OVER && m_go && m_score > m_high) m_high = m_score;
        case (m_state)
            S_IDLE: if (rise) begin
                m_state = S_PLAY;
                m_score = 0;
            end
            S_PLAY: begin
                if (p) m_score = (m_score < SM) ? m_score + 1 : SM;
                if (tick && (h || b > YM)) begin
                    m_state = S_OVER;
                    go_next = 1'b1;
                    m_hold  = HF;
                end
            end
            default: begin
                if (rise && m_hold == 0) m_state = S_IDLE;
                else if (tick && m_hold > 0) m_hold--;
            end
        endcase
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = s;
        m_go    = go_next;
        n++;
    endtask

    task automatic check_all();
        check_eq("frame_tick", 32'(frame_tick), 32'(m_tick()));
        check_eq("state", 32'(state), 32'(m_state));
        check_eq("count", 32'(count), 32'(m_count()));
        check_eq("score", 32'(score), 32'(m_score));
        check_eq("high_score", 32'(high_score), 32'(m_high));
        check_eq("game_over", 32'(game_over), 32'(m_go));
    endtask

    // One clk: entered and left at a falling edge.
    task automatic cyc(input bit s, input bit h, input bit p, input int b);
        check_all();
        start     = s;
        hit       = h;
        pipe_pass = p;
        birdy     = 11'(b);
        @(posedge clk);
        model_step(s, h, p, b);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 1'b0, 100);
    endtask

    task automatic press_start();
        cyc(1'b1, 1'b0, 1'b0, 100);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 100);
    endtask

    task automatic pulses(input int k);
        for (int i = 0; i < k; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 100);
            cyc(1'b0, 1'b0, 1'b0, 100);
        end
    endtask

    task automatic wait_ticks(input int k);
        int got = 0;
        int guard = 0;
        bit t;
        while (got < k && guard < 100) begin
            t = m_tick();
            cyc(1'b0, 1'b0, 1'b0, 100);
            if (t) got++;
            guard++;
        end
    endtask

    task automatic end_by_birdy(input int b);
        int guard = 0;
        while (m_state != S_OVER && guard < 20) begin
            cyc(1'b0, 1'b0, 1'b0, b);
            guard++;
        end
        check_eq("over_by_birdy", 32'(state), 32'(S_OVER));
        check_eq("go_pulse_birdy", 32'(game_over), 32'd1);
    endtask

    task automatic random_cycles(input int k);
        bit s = 1'b0;
        bit h;
        bit p;
        int b;
        for (int i = 0; i < k; i++) begin
            if ($urandom_range(7) == 0) s = ~s;
            h = ($urandom_range(15) == 0);
            p = ($urandom_range(3) == 0);
            if ($urandom_range(19) == 0) b = int'($urandom_range(2047, YM + 1));
            else b = int'($urandom_range(YM, 0));
            cyc(s, h, p, b);
        end
    endtask

    initial begin
        int guard;
        rst_n     = 1'b0;
        start     = 1'b0;
        hit       = 1'b0;
        pipe_pass = 1'b0;
        birdy     = 11'd100;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        check_eq("rst_state", 32'(state), 32'(3'b001));
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_tick", 32'(frame_tick), 32'd0);

        // Frame ticks and count wrap at the 60th/61st tick.
        for (int i = 0; i < 250; i++) begin
            if (n == 60 * FD - 1) check_eq("count_59", 32'(count), 32'd59);
            if (n == 61 * FD - 1) check_eq("count_wrap0", 32'(count), 32'd0);
            cyc(1'b0, 1'b0, 1'b0, 100);
        end
        check_eq("idle_state", 32'(state), 32'(S_IDLE));

        // Game A: held start gives one transition, then hit ends the game.
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 100);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 100);
        check_eq("held_start_play", 32'(state), 32'(S_PLAY));
        check_eq("score_cleared", 32'(score), 32'd0);
        pulses(5);
        check_eq("score_5", 32'(score), 32'd5);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b0, YM);
        check_eq("birdy_934_play", 32'(state), 32'(S_PLAY));
        for (int i = 0; i < 12; i++) cyc(1'b0, !m_tick(), 1'b0, 100);
        check_eq("hit_off_tick", 32'(state), 32'(S_PLAY));
        pulses(2);
        guard = 0;
        while (!m_tick() && guard < 10) begin
            cyc(1'b0, 1'b0, 1'b0, 100);
            guard++;
        end
        cyc(1'b0, 1'b1, 1'b1, 100);
        check_eq("hit_pass_score", 32'(score), 32'd8);
        check_eq("hit_over", 32'(state), 32'(S_OVER));
        check_eq("hit_go_pulse", 32'(game_over), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 100);
        check_eq("high_8", 32'(high_score), 32'd8);
        check_eq("go_one_clk", 32'(game_over), 32'd0);

        // OVER hold: start after 2 ticks ignored, after all 3 accepted.
        wait_ticks(2);
        press_start();
        check_eq("hold_ignore", 32'(state), 32'(S_OVER));
        wait_ticks(2);
        press_start();
        check_eq("hold_release", 32'(state), 32'(S_IDLE));
        check_eq("score_retained", 32'(score), 32'd8);

        // Game B: equal score leaves high_score alone.
        press_start();
        check_eq("b_play", 32'(state), 32'(S_PLAY));
        pulses(8);
        end_by_birdy(YM + 1);
        cyc(1'b0, 1'b0, 1'b0, 100);
        check_eq("high_equal", 32'(high_score), 32'd8);
        wait_ticks(4);
        press_start();

        // Game C: saturation, then ceiling wrap ends the game.
        press_start();
        pulses(998);
        check_eq("score_998", 32'(score), 32'd998);
        pulses(3);
        check_eq("score_sat", 32'(score), 32'd999);
        end_by_birdy(2044);
        cyc(1'b0, 1'b0, 1'b0, 100);
        check_eq("high_999", 32'(high_score), 32'd999);
        wait_ticks(4);
        press_start();

        // Randomized play.
        random_cycles(2500);

        // Asynchronous reset in the middle of PLAY.
        guard = 0;
        while (m_state != S_PLAY && guard < 200) begin
            cyc(guard[2], 1'b0, 1'b0, 100);
            guard++;
        end
        idle_cycles(5);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_state", 32'(state), 32'(3'b001));
        check_eq("arst_count", 32'(count), 32'd0);
        check_eq("arst_score", 32'(score), 32'd0);
        check_eq("arst_high", 32'(high_score), 32'd0);
        check_eq("arst_tick", 32'(frame_tick), 32'd0);
        check_eq("arst_go", 32'(game_over), 32'd0);
        start = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        random_cycles(1500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Top-level game sequencer that sits directly upstream of the bird sprite stage. It generates the per-frame tick and the 6-bit animation counter. It drives the one-hot game state (bit1 = playing) that the bird stage consumes, and it decides game-over from collision and bird-y bounds. It also keeps the current score and the high score for the score display.

Parameters:
FRAME_DIV, 1666667, clk cycles per frame tick (100 MHz / 60 Hz); must be >= 2.
ANIM_WRAP, 60, count wraps from ANIM_WRAP-1 to 0.
Y_MAX, 934, largest legal bird top-left y (1024 - 90 sprite height).
HOLD_FRAMES, 90, frames in OVER before start is accepted.
SCORE_MAX, 999, score saturation value.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  raw start button, asynchronous to clk.
hit  in  1  level; bird/pipe overlap from collision stage, synchronous to clk.
pipe_pass  in  1  one-clk pulse when a pipe's right edge passes the bird.
birdy  in  11  current bird y from the bird stage.
frame_tick  out  1  one-clk pulse every FRAME_DIV clks; the frame strobe for downstream movers.
state  out  3  one-hot: 3'b001 IDLE, 3'b010 PLAY, 3'b100 OVER.
count  out  6  animation counter, 0..ANIM_WRAP-1.
score  out  10  current score, binary.
high_score  out  10  best score since reset.
game_over  out  1  one-clk pulse on the PLAY->OVER transition.

Behaviour:
- Reset (async assert, clk-synchronous release) values:
  - state=3'b001; count=0; score=0; high_score=0.
  - frame_tick=0; game_over=0; divider=0; hold counter=0; start synchronizer=0.
- Divider: counts 0..FRAME_DIV-1 and then wraps. frame_tick=1 for exactly the one clk where the divider equals FRAME_DIV-1 (registered output). The divider runs in all states.
- count: increments on frame_tick and wraps ANIM_WRAP-1 -> 0. It runs in all states and is never cleared except by reset.
- start: 2-flop synchronizer, then rising-edge detect (start_rise, one clk). A held button produces only one event.
- FSM:
  - IDLE: on start_rise -> PLAY; in the same edge, score <= 0.
  - PLAY: on a clk where frame_tick=1 and (hit=1 or birdy > Y_MAX) -> OVER.
    - game_over=1 on that clk edge's output (registered, one clk).
    - The hold counter loads HOLD_FRAMES.
    - hit and the bounds check are evaluated only on frame_tick clks; hit pulses between ticks are ignored.
    - birdy > Y_MAX also covers ceiling wrap, since birdy-8 underflow gives a value >= 2040.
  - OVER:
    - The hold counter decrements on each frame_tick until it reaches 0.
    - start_rise with the hold counter != 0 is ignored.
    - start_rise with the hold counter == 0 -> IDLE. score is retained for display until the next IDLE->PLAY.
- Score:
  - In PLAY, pipe_pass=1 -> score <= score+1, saturating at SCORE_MAX (stays 999).
  - pipe_pass is ignored in IDLE and OVER.
- Simultaneous pipe_pass with the game-over condition on the same clk: the increment is applied and the transition also occurs.
- High score: on the first clk in OVER (one clk after the transition), if score > high_score then high_score <= score. Equal scores do not update.
- Simultaneous start_rise and frame_tick in IDLE: the transition to PLAY proceeds, and count still increments.
- Reset asserted mid-PLAY returns all outputs to their reset values immediately, with no clk needed.

Test Plan:
- Reset/tick (FRAME_DIV=4, ANIM_WRAP=60):
  - release rst_n -> frame_tick pulses on clk 4, 8, 12, ...
  - count reads 59 then 0 on the 60th and 61st ticks.
  - state=3'b001.
- Start and score:
  - Hold start high for 20 clks -> exactly one IDLE->PLAY; state=3'b010; score=0.
  - Then 5 pipe_pass pulses -> score=5.
  - Force score to 998, then 3 more pulses -> score=999.
- Game over by bounds:
  - In PLAY, set birdy=935 -> at the next frame_tick, state=3'b100 and game_over pulses for 1 clk.
  - birdy=934 -> stays in PLAY.
  - birdy=2044 (wrap) -> OVER.
- Hit and simultaneity:
  - Pulse hit between ticks -> no transition.
  - hit=1 and pipe_pass=1 on the same frame_tick clk with score=7 -> score=8, OVER.
  - high_score=8 one clk later.
  - A second game ending at score 8 leaves high_score=8.
- OVER hold (HOLD_FRAMES=3): start_rise after 2 ticks in OVER is ignored; start_rise after 3 ticks -> IDLE, with score unchanged.
- Async reset: assert rst_n=0 mid-PLAY between clk edges -> state=3'b001 and count=0 immediately.
